// File: rtl/fisc_uart_rx.sv
// fisc_uart_rx - serial 8N1 receiver for the FISC UART.
//
// Deserialises frames arriving on rx and holds the received byte for the CPU.
// data_out feeds the UARTval input of the data-bus mux. rx_ready and overrun
// drive the UART status inputs of the jump-logic mux.
//
// Build option: define UART_RX_FIFO_EN to replace the single holding register
// with a 4-entry FIFO. When the macro is undefined, the holding register is used.
//
// Ports
//   i_clk        in   1  clock, rising edge
//   reset        in   1  synchronous reset, active high
//   rx           in   1  asynchronous serial input, idle high
//   UARTwrite    in   1  active-low CPU read strobe, one read per low cycle
//   data_out     out  8  held byte (FIFO head in the FIFO build)
//   rx_ready     out  1  a byte is available
//   overrun      out  1  sticky, a byte was dropped because storage was full
//   framing_err  out  1  sticky, the last frame had a stop bit of 0
`timescale 1ns/1ps
module fisc_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       UARTwrite,
    output logic [7:0] data_out,
    output logic       rx_ready,
    output logic       overrun,
    output logic       framing_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic             sync1_r, sync2_r, prev_r;
    logic             vld1_r, vld2_r, armed_r;
    state_t           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bitidx_r, bitidx_n;
    logic [7:0]       shift_r, shift_n;
    logic             commit_s, stop_bad_s;
    logic             read_s;

    assign read_s = ~UARTwrite;

    // Two-flop synchroniser plus one extra flop for falling-edge detection.
    // The reset value of the sync flops is an artificial high, so start
    // detection is armed only once a real sample has shown the line high;
    // a line held low out of reset therefore never looks like a start edge.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
            vld1_r  <= 1'b0;
            vld2_r  <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            vld1_r  <= 1'b1;
            vld2_r  <= vld1_r;
            if (vld2_r && sync2_r) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Receive FSM state, bit counter, bit index and shift register.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            bitidx_r <= 3'd0;
            shift_r  <= 8'd0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            bitidx_r <= bitidx_n;
            shift_r  <= shift_n;
        end
    end

    // Next-state logic; samples are taken when the counter reaches zero.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        bitidx_n   = bitidx_r;
        shift_n    = shift_r;
        commit_s   = 1'b0;
        stop_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (armed_r && prev_r && !sync2_r) begin
                    cnt_n   = HALF_CNT;
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else if (sync2_r) begin
                    state_n = ST_IDLE;      // false start, no flag
                end else begin
                    cnt_n    = FULL_CNT;
                    bitidx_n = 3'd0;
                    state_n  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else begin
                    shift_n = {sync2_r, shift_r[7:1]};   // LSB arrives first
                    cnt_n   = FULL_CNT;
                    if (bitidx_r == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bitidx_n = bitidx_r + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_n = cnt_r - CNT_ONE;
                end else begin
                    state_n = ST_IDLE;
                    if (sync2_r) begin
                        commit_s = 1'b1;
                    end else begin
                        stop_bad_s = 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Sticky framing error: set by a bad stop bit, cleared by a good frame.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            framing_err <= 1'b0;
        end else if (stop_bad_s) begin
            framing_err <= 1'b1;
        end else if (commit_s) begin
            framing_err <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_mem_r [4];
    logic [1:0] wr_ptr_r, rd_ptr_r, rd_ptr_n;
    logic [2:0] count_r, count_n;
    logic [7:0] head_n;
    logic       push_s, pop_s;

    // Push/pop decisions and the head value that data_out will show next.
    // A freshly pushed byte is the head when it is the only entry left.
    always_comb begin
        pop_s    = read_s && (count_r != 3'd0);
        push_s   = commit_s && ((count_r != 3'd4) || pop_s);
        count_n  = count_r + {2'b00, push_s} - {2'b00, pop_s};
        rd_ptr_n = pop_s ? (rd_ptr_r + 2'd1) : rd_ptr_r;
        if (count_n == 3'd0) begin
            head_n = 8'd0;
        end else if (push_s && (count_n == 3'd1)) begin
            head_n = shift_r;
        end else begin
            head_n = fifo_mem_r[rd_ptr_n];
        end
    end

    // FIFO storage, pointers and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            data_out <= 8'd0;
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            rd_ptr_r <= rd_ptr_n;
            count_r  <= count_n;
            data_out <= head_n;
            rx_ready <= (count_n != 3'd0);
            if (commit_s && !push_s) begin
                overrun <= 1'b1;
            end else if (read_s) begin
                overrun <= 1'b0;
            end
        end
    end
`else
    // Single holding register. A read on the commit cycle frees the slot,
    // so the new byte is loaded instead of being counted as an overrun.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            data_out <= 8'd0;
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
        end else if (commit_s && read_s) begin
            data_out <= shift_r;
            rx_ready <= 1'b1;
            overrun  <= 1'b0;
        end else if (commit_s) begin
            if (!rx_ready) begin
                data_out <= shift_r;
                rx_ready <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (read_s) begin
            rx_ready <= 1'b0;
            overrun  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fisc_uart_rx.sv
// Self-checking bench for fisc_uart_rx (CLKS_PER_BIT = 16). A scoreboard queue
// holds the bytes the receiver should be holding; frames push into it and CPU
// reads pop from it. Works for both the holding-register and FIFO builds.
`timescale 1ns/1ps
module tb_fisc_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // Rising edges from the rx falling edge to the stop sample: two sync
    // flops, one edge to register the start, HALF+1 edges in START, then
    // eight data bits and the stop bit at CPB edges each.
    localparam int STOP_SAMPLE = 3 + (HALF + 1) + 9 * CPB;

    logic       i_clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       UARTwrite;
    logic [7:0] data_out;
    logic       rx_ready;
    logic       overrun;
    logic       framing_err;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;

    fisc_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (i_clk),
        .reset       (reset),
        .rx          (rx),
        .UARTwrite   (UARTwrite),
        .data_out    (data_out),
        .rx_ready    (rx_ready),
        .overrun     (overrun),
        .framing_err (framing_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Drives one frame from a negedge; cut>0 abandons it after cut cycles.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int cut);
        int idx;
        for (int c = 0; c < 10 * CPB; c++) begin
            if (cut != 0 && c == cut) break;
            idx = c / CPB;
            if (idx == 0)      rx = 1'b0;
            else if (idx == 9) rx = stop_bit;
            else               rx = b[idx-1];
            @(negedge i_clk);
        end
        rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_ferr = 1'b0;
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                      exp_ovr = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        drive_frame(b, stop_bit, 0);
        model_frame(b, stop_bit);
        idle(4);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_rdy"}, {31'd0, rx_ready}, {31'd0, exp_q.size() != 0});
        check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, exp_ovr});
        check({tag, "_ferr"}, {31'd0, framing_err}, {31'd0, exp_ferr});
        if (exp_q.size() != 0)
            check({tag, "_data"}, {24'd0, data_out}, {24'd0, exp_q[0]});
    endtask

    task automatic do_read(input string tag);
        UARTwrite = 1'b0;
        @(negedge i_clk);
        UARTwrite = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_ovr = 1'b0;
        check_status(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        rx = 1'b1; UARTwrite = 1'b1; reset = 1'b1;
        exp_ovr = 1'b0; exp_ferr = 1'b0;
        idle(3);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_rdy", {31'd0, rx_ready}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_ferr", {31'd0, framing_err}, 32'd0);
        reset = 1'b0;
        idle(10);

        // 1: single byte, then one read
        send(8'h55, 1'b1);
        check_status("t1");
        do_read("t1r");
`ifdef UART_RX_FIFO_EN
        check("t1_after_read", {24'd0, data_out}, 32'h00);
`else
        check("t1_after_read", {24'd0, data_out}, 32'h55);
`endif

        // 2: two bytes without a read
        send(8'hA3, 1'b1);
        send(8'h3C, 1'b1);
        check_status("t2");
        for (int i = 0; i < DEPTH && exp_q.size() != 0; i++) do_read("t2r");

        // 3: glitch shorter than half a bit is a false start
        rx = 1'b0; idle(5); rx = 1'b1; idle(40);
        check_status("t3");

        // 4: bad stop bit, then a good frame clears the flag
        send(8'hFF, 1'b0);
        check_status("t4a");
        send(8'h12, 1'b1);
        check_status("t4b");

        // 5: reset in the middle of data bit 4
        drive_frame(8'h81, 1'b1, 5 * CPB + HALF);
        reset = 1'b1;
        @(negedge i_clk);
        check("t5_data", {24'd0, data_out}, 32'd0);
        check("t5_rdy", {31'd0, rx_ready}, 32'd0);
        check("t5_ovr", {31'd0, overrun}, 32'd0);
        check("t5_ferr", {31'd0, framing_err}, 32'd0);
        reset = 1'b0;
        exp_q.delete(); exp_ovr = 1'b0; exp_ferr = 1'b0;
        idle(20);
        send(8'h81, 1'b1);
        check_status("t5b");
        do_read("t5r");

        // 6: read on the very cycle of the stop sample
        send(8'h10, 1'b1);
        fork
            drive_frame(8'h20, 1'b1, 0);
            begin
                idle(STOP_SAMPLE - 1);
                UARTwrite = 1'b0;
                idle(1);
                UARTwrite = 1'b1;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h20);
        exp_ovr = 1'b0; exp_ferr = 1'b0;
        idle(4);
        check_status("t6");
        check("t6_data_explicit", {24'd0, data_out}, 32'h20);
        do_read("t6r");

        // random bytes
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom_range(0, 255));
            send(rb, 1'b1);
            check_status("rnd");
            do_read("rndr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
